// File: rtl/qspi_target_sampled.sv
// QSPI target sampled on the system clock: decodes a one-byte command, then streams
// write data to an rx valid/ready port or shifts tx bytes out in single or quad mode.
//
// state  | meaning
// IDLE   | CSN high, waiting for the synchronized CSN falling edge
// CMD    | shifting the command byte in on sd[0]
// WR1    | single-line write, one bit per SCK rise
// WRQ    | quad write, one nibble per SCK rise
// DUMMY  | counting dummy SCK rises before read data
// RD1    | single-line read, one bit per SCK fall on sd[1]
// RDQ    | quad read, one nibble per SCK fall
// IGNORE | unknown command, idle until CSN deasserts
module qspi_target_sampled #(
   parameter int SYNC_STAGES  = 2,
   parameter int DUMMY_CYCLES = 8
) (
   input  logic       sys_clk_i,
   input  logic       rst_i,
   input  logic       sck_i,
   input  logic       csn_i,
   input  logic [3:0] sd_i,
   output logic [3:0] sd_o,
   output logic [3:0] sd_oe_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       busy_o,
   output logic       eot_o,
   output logic       overrun_o,
   output logic       underrun_o
);

   localparam int DCW = (DUMMY_CYCLES > 0) ? $clog2(DUMMY_CYCLES + 1) : 1;
   localparam logic [DCW-1:0] DUMMY_INIT = DCW'(DUMMY_CYCLES);
   localparam logic [DCW-1:0] DCNT_ONE   = DCW'(1);

   typedef enum logic [2:0] {IDLE, CMD, WR1, WRQ, DUMMY, RD1, RDQ, IGNORE} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, csn_sync;
   logic [3:0]             sd_sync [SYNC_STAGES];
   logic                   sck_s, csn_s, sck_q, csn_q;
   logic [3:0]             sd_s;
   logic                   rise, fall, csn_fall, csn_rise;

   logic [2:0]     bit_cnt;
   logic [7:0]     shreg, tx_sh, rx_byte, tx_byte, tx_src;
   logic [DCW-1:0] dcnt;
   logic           rd_quad, wr_done, rd_load, quad_out;

   always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
         sck_sync <= '0;
         csn_sync <= '1;
         sck_q    <= 1'b0;
         csn_q    <= 1'b1;
         for (int i = 0; i < SYNC_STAGES; i++) sd_sync[i] <= 4'h0;
      end else begin
         sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck_i};
         csn_sync   <= {csn_sync[SYNC_STAGES-2:0], csn_i};
         sd_sync[0] <= sd_i;
         for (int i = 1; i < SYNC_STAGES; i++) sd_sync[i] <= sd_sync[i-1];
         sck_q <= sck_s;
         csn_q <= csn_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign csn_s    = csn_sync[SYNC_STAGES-1];
   assign sd_s     = sd_sync[SYNC_STAGES-1];
   assign rise     = sck_s & ~sck_q & ~csn_s;
   assign fall     = ~sck_s & sck_q & ~csn_s;
   assign csn_fall = ~csn_s & csn_q;
   assign csn_rise = csn_s & ~csn_q;

   assign rx_byte  = (state == WRQ) ? {shreg[3:0], sd_s} : {shreg[6:0], sd_s[0]};
   assign wr_done  = rise & (((state == WR1) & (bit_cnt == 3'd7)) | ((state == WRQ) & bit_cnt[0]));
   assign rd_load  = fall & (((state == RD1) & (bit_cnt == 3'd0)) | ((state == RDQ) & ~bit_cnt[0]));
   assign tx_byte  = tx_valid_i ? tx_data_i : 8'hFF;
   assign tx_src   = rd_load ? tx_byte : tx_sh;
   assign quad_out = (state == RDQ);

   assign tx_ready_o = rd_load;
   assign underrun_o = rd_load & ~tx_valid_i;
   assign overrun_o  = wr_done & rx_valid_o & ~rx_ready_i;
   assign eot_o      = csn_rise & (state inside {WR1, WRQ, DUMMY, RD1, RDQ});
   assign busy_o     = ~csn_s;

   always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (csn_rise) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:  if (csn_fall) state_nxt = CMD;
            CMD: begin
               if (rise && bit_cnt == 3'd7) begin
                  case (rx_byte)
                     8'h02:   state_nxt = WR1;
                     8'h32:   state_nxt = WRQ;
                     8'h03:   state_nxt = (DUMMY_CYCLES == 0) ? RD1 : DUMMY;
                     8'h6B:   state_nxt = (DUMMY_CYCLES == 0) ? RDQ : DUMMY;
                     default: state_nxt = IGNORE;
                  endcase
               end
            end
            DUMMY: if (rise && dcnt == DCNT_ONE) state_nxt = rd_quad ? RDQ : RD1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         tx_sh      <= 8'h00;
         dcnt       <= '0;
         rd_quad    <= 1'b0;
         sd_o       <= 4'h0;
         sd_oe_o    <= 4'h0;
         rx_data_o  <= 8'h00;
         rx_valid_o <= 1'b0;
      end else begin
         if (csn_fall) bit_cnt <= 3'd0;
         if (rise && (state inside {CMD, WR1, WRQ})) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (rise && state == CMD && bit_cnt == 3'd7) begin
            dcnt    <= DUMMY_INIT;
            rd_quad <= (rx_byte == 8'h6B);
         end
         if (rise && state == DUMMY) dcnt <= dcnt - DCNT_ONE;
         // the bit counter wraps at 8, so even counts mark nibble boundaries in RDQ
         if (fall && (state inside {RD1, RDQ})) begin
            bit_cnt <= bit_cnt + 3'd1;
            sd_oe_o <= quad_out ? 4'hF : 4'b0010;
            sd_o    <= quad_out ? tx_src[7:4] : {2'b00, tx_src[7], 1'b0};
            tx_sh   <= quad_out ? {tx_src[3:0], 4'h0} : {tx_src[6:0], 1'b0};
         end
         if (csn_rise) begin
            sd_oe_o <= 4'h0;
            sd_o    <= 4'h0;
         end
         if (wr_done) begin
            if (!rx_valid_o || rx_ready_i) begin
               rx_data_o  <= rx_byte;
               rx_valid_o <= 1'b1;
            end
         end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_qspi_target_sampled.sv
// Bench for qspi_target_sampled: a mode-0 QSPI master model, a table of directed frames,
// randomized frames checked against a byte-level reference model, and reset/abort sequences.
module tb_qspi_target_sampled;

   localparam int SYNC  = 2;
   localparam int DUMMY = 8;
   localparam int HALF  = 6;

   logic       sys_clk_i  = 1'b0;
   logic       rst_i      = 1'b1;
   logic       sck_i      = 1'b0;
   logic       csn_i      = 1'b1;
   logic [3:0] sd_i       = 4'h0;
   logic       rx_ready_i = 1'b0;
   logic [7:0] tx_data_i  = 8'h00;
   logic       tx_valid_i = 1'b0;
   logic [3:0] sd_o, sd_oe_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, tx_ready_o, busy_o, eot_o, overrun_o, underrun_o;

   always #5 sys_clk_i = ~sys_clk_i;

   qspi_target_sampled #(.SYNC_STAGES(SYNC), .DUMMY_CYCLES(DUMMY)) dut (
      .sys_clk_i(sys_clk_i), .rst_i(rst_i), .sck_i(sck_i), .csn_i(csn_i), .sd_i(sd_i),
      .sd_o(sd_o), .sd_oe_o(sd_oe_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
      .tx_ready_o(tx_ready_o), .busy_o(busy_o), .eot_o(eot_o), .overrun_o(overrun_o),
      .underrun_o(underrun_o));

   typedef struct {
      logic [7:0]       cmd;
      int               n;
      logic             rdy;
      logic             tv;
      logic [3:0][7:0]  dat;
      int               exp_rx;
      logic [3:0][7:0]  erx;
      logic             exp_hv;
      logic [7:0]       exp_hold;
      int               exp_ovr;
      int               exp_und;
      int               exp_pop;
      int               exp_eot;
      logic [3:0][7:0]  erd;
   } vec_t;

   int         n_chk = 0, n_pass = 0;
   int         n_ovr = 0, n_und = 0, n_eot = 0, n_pop = 0;
   logic [7:0] tx_mem [256];
   logic [7:0] rx_log [256];
   logic [7:0] tx_idx = 8'h00;
   logic [7:0] rx_cnt = 8'h00;
   logic [7:0] rd [4];
   vec_t       tbl [7];

   // stream-side consumer/producer; tx_data_i only advances once the pop strobe has gone
   initial forever begin
      @(negedge sys_clk_i);
      if (rx_valid_o && rx_ready_i) begin
         rx_log[rx_cnt] = rx_data_o;
         rx_cnt++;
      end
      if (overrun_o)  n_ovr++;
      if (underrun_o) n_und++;
      if (eot_o)      n_eot++;
      if (tx_ready_o) begin
         n_pop++;
         tx_idx++;
      end else begin
         tx_data_i = tx_mem[tx_idx];
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk_i);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   task automatic clk_bit(input logic [3:0] mosi, output logic [3:0] miso, output logic [3:0] oe);
      sd_i = mosi;
      tick(HALF);
      sck_i = 1'b1;
      miso  = sd_o;
      oe    = sd_oe_o;
      tick(HALF);
      sck_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic quad);
      logic [3:0] m, o;
      if (quad) begin
         clk_bit(b[7:4], m, o);
         clk_bit(b[3:0], m, o);
      end else begin
         for (int i = 7; i >= 0; i--) clk_bit({3'b000, b[i]}, m, o);
      end
   endtask

   task automatic start_frame();
      csn_i = 1'b0;
      tick(HALF);
   endtask

   task automatic end_frame();
      tick(HALF);
      csn_i = 1'b1;
      tick(SYNC + 4);
   endtask

   function automatic vec_t mk(input logic [7:0] cmd, input int n, input logic rdy, input logic tv,
                               input logic [31:0] dat, input int exp_rx, input logic [31:0] erx,
                               input logic hv, input logic [7:0] hold, input int ovr, input int und,
                               input int pop, input int eot, input logic [31:0] erd);
      vec_t v;
      v.cmd = cmd; v.n = n; v.rdy = rdy; v.tv = tv; v.dat = dat;
      v.exp_rx = exp_rx; v.erx = erx; v.exp_hv = hv; v.exp_hold = hold;
      v.exp_ovr = ovr; v.exp_und = und; v.exp_pop = pop; v.exp_eot = eot; v.erd = erd;
      return v;
   endfunction

   // byte-level reference: what a frame must produce, from the command's rules alone
   function automatic vec_t model(input logic [7:0] cmd, input int n, input logic rdy,
                                  input logic tv, input logic [31:0] dat);
      vec_t v;
      logic is_rd, quad;
      int   bpb, loads;
      v = mk(cmd, n, rdy, tv, dat, 0, 0, 1'b0, 8'h00, 0, 0, 0, 1, 0);
      is_rd = (cmd == 8'h03) || (cmd == 8'h6B);
      quad  = (cmd == 8'h32) || (cmd == 8'h6B);
      bpb   = quad ? 2 : 8;
      if (!is_rd) begin
         if (rdy) begin
            v.exp_rx = n;
            v.erx    = dat;
         end else begin
            v.exp_rx   = 1;
            v.erx[0]   = v.dat[0];
            v.exp_hv   = 1'b1;
            v.exp_hold = v.dat[0];
            v.exp_ovr  = n - 1;
         end
      end else begin
         // falls seen in the read phase: the one closing the last dummy cycle plus one per data beat
         loads     = (1 + n * bpb + bpb - 1) / bpb;
         v.exp_pop = loads;
         v.exp_und = tv ? 0 : loads;
         for (int k = 0; k < n; k++) v.erd[k] = tv ? v.dat[k] : 8'hFF;
      end
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string id);
      logic [7:0] b_rx, b_tx, b, hold;
      logic [3:0] m, o;
      logic       is_rd, quad, hv;
      int         b_ovr, b_und, b_pop, b_eot, oe_bad;
      is_rd  = (v.cmd == 8'h03) || (v.cmd == 8'h6B);
      quad   = (v.cmd == 8'h32) || (v.cmd == 8'h6B);
      b_rx   = rx_cnt; b_tx = tx_idx;
      b_ovr  = n_ovr; b_und = n_und; b_pop = n_pop; b_eot = n_eot;
      oe_bad = 0;
      for (int k = 0; k <= v.n; k++) tx_mem[8'(b_tx + 8'(k))] = (k < v.n) ? v.dat[k] : 8'hC3;
      rx_ready_i = v.rdy;
      tx_valid_i = v.tv;
      start_frame();
      send_byte(v.cmd, 1'b0);
      if (is_rd) begin
         repeat (DUMMY) clk_bit(4'h0, m, o);
         for (int k = 0; k < v.n; k++) begin
            b = 8'h00;
            for (int j = 0; j < (quad ? 2 : 8); j++) begin
               clk_bit(4'h0, m, o);
               b = quad ? {b[3:0], m} : {b[6:0], m[1]};
               if (o !== (quad ? 4'hF : 4'b0010)) oe_bad++;
            end
            rd[k] = b;
         end
      end else begin
         for (int k = 0; k < v.n; k++) send_byte(v.dat[k], quad);
      end
      end_frame();
      hold = rx_data_o;
      hv   = rx_valid_o;
      chk({id, " sd_oe after csn"}, sd_oe_o, 4'h0);
      chk({id, " busy after csn"}, busy_o, 1'b0);
      rx_ready_i = 1'b1;
      tick(3);
      rx_ready_i = 1'b0;
      tx_valid_i = 1'b0;
      chk({id, " oe during read"}, oe_bad, 0);
      chk({id, " rx_valid held"}, hv, v.exp_hv);
      if (v.exp_hv) chk({id, " rx_data held"}, hold, v.exp_hold);
      chk({id, " rx pushes"}, 8'(rx_cnt - b_rx), v.exp_rx);
      for (int k = 0; k < v.exp_rx; k++)
         chk($sformatf("%s rx byte %0d", id, k), rx_log[8'(b_rx + 8'(k))], v.erx[k]);
      chk({id, " overrun"}, n_ovr - b_ovr, v.exp_ovr);
      chk({id, " underrun"}, n_und - b_und, v.exp_und);
      chk({id, " tx pops"}, n_pop - b_pop, v.exp_pop);
      chk({id, " eot"}, n_eot - b_eot, v.exp_eot);
      if (is_rd)
         for (int k = 0; k < v.n; k++) chk($sformatf("%s read byte %0d", id, k), rd[k], v.erd[k]);
   endtask

   initial begin
      logic [3:0] m, o;
      logic [7:0] cmds [4];
      int         b_rx, b_eot;

      tbl[0] = mk(8'h02, 2, 1'b1, 1'b0, 32'h0000_3CA5, 2, 32'h0000_3CA5, 1'b0, 8'h00, 0, 0, 0, 1, 0);
      tbl[1] = mk(8'h32, 3, 1'b0, 1'b0, 32'h0033_2211, 1, 32'h0000_0011, 1'b1, 8'h11, 2, 0, 0, 1, 0);
      tbl[2] = mk(8'h03, 1, 1'b0, 1'b1, 32'h0000_005A, 0, 0, 1'b0, 8'h00, 0, 0, 2, 1, 32'h0000_005A);
      tbl[3] = mk(8'h6B, 2, 1'b0, 1'b0, 32'h0000_1234, 0, 0, 1'b0, 8'h00, 0, 3, 3, 1, 32'h0000_FFFF);
      tbl[4] = mk(8'h9F, 2, 1'b1, 1'b0, 32'h0000_FF00, 0, 0, 1'b0, 8'h00, 0, 0, 0, 0, 0);
      tbl[5] = mk(8'h02, 1, 1'b0, 1'b0, 32'h0000_00C5, 1, 32'h0000_00C5, 1'b1, 8'hC5, 0, 0, 0, 1, 0);
      tbl[6] = mk(8'h6B, 1, 1'b0, 1'b1, 32'h0000_0096, 0, 0, 1'b0, 8'h00, 0, 0, 2, 1, 32'h0000_0096);
      cmds[0] = 8'h02; cmds[1] = 8'h32; cmds[2] = 8'h03; cmds[3] = 8'h6B;
      for (int i = 0; i < 256; i++) tx_mem[i] = 8'h00;

      tick(4);
      chk("reset sd_oe", sd_oe_o, 4'h0);
      chk("reset sd_o", sd_o, 4'h0);
      chk("reset rx_valid", rx_valid_o, 1'b0);
      chk("reset rx_data", rx_data_o, 8'h00);
      chk("reset busy", busy_o, 1'b0);
      chk("reset strobes", {tx_ready_o, eot_o, overrun_o, underrun_o}, 4'h0);
      rst_i = 1'b0;
      tick(4);

      // reset mid-frame while a byte is pending and the quad read is driving the pads
      rx_ready_i = 1'b0;
      start_frame();
      send_byte(8'h02, 1'b0);
      send_byte(8'h77, 1'b0);
      end_frame();
      chk("pending rx_valid", rx_valid_o, 1'b1);
      chk("pending rx_data", rx_data_o, 8'h77);
      start_frame();
      send_byte(8'h6B, 1'b0);
      repeat (DUMMY) clk_bit(4'h0, m, o);
      clk_bit(4'h0, m, o);
      chk("mid-read sd_oe", sd_oe_o, 4'hF);
      chk("mid-read busy", busy_o, 1'b1);
      rst_i = 1'b1;
      tick(1);
      chk("rst sd_oe", sd_oe_o, 4'h0);
      chk("rst sd_o", sd_o, 4'h0);
      chk("rst rx_valid", rx_valid_o, 1'b0);
      chk("rst rx_data", rx_data_o, 8'h00);
      chk("rst busy", busy_o, 1'b0);
      chk("rst strobes", {tx_ready_o, eot_o, overrun_o, underrun_o}, 4'h0);
      csn_i = 1'b1;
      tick(3);
      rst_i = 1'b0;
      tick(4);

      for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // abort: write command plus 5 bits, then CSN high
      rx_ready_i = 1'b1;
      b_rx  = rx_cnt;
      b_eot = n_eot;
      start_frame();
      send_byte(8'h02, 1'b0);
      repeat (5) clk_bit(4'h1, m, o);
      end_frame();
      tick(3);
      rx_ready_i = 1'b0;
      chk("abort rx pushes", 8'(rx_cnt - 8'(b_rx)), 0);
      chk("abort eot", n_eot - b_eot, 1);

      for (int i = 0; i < 24; i++)
         run_vec(model(cmds[$urandom_range(0, 3)], int'($urandom_range(1, 4)), 1'($urandom),
                       1'($urandom), $urandom), $sformatf("rnd%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
